db9md_pad_scan: RTL and testbench



---
 rtl/db9md_pkg.sv | 35 +++
 rtl/db9md_sync.sv | 33 +++
 rtl/db9md_pad_scan.sv | 263 ++++++++++++++++++++++++++
 tb/tb_db9md_pad_scan.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db9md_pkg.sv
// rtl/db9md_pkg.sv - shared constants and types for the DB9 Mega Drive pad scanner
//
// Purpose: button bit positions of the decoded 16-bit joystick word, the
//          scanner FSM state type and the SELECT phase numbers at which the
//          scanner samples the pads.
// Ports:   none (package).
package db9md_pkg;

  // Decoded word layout; bits [15:12] are always zero.
  localparam int BIT_R     = 0;
  localparam int BIT_L     = 1;
  localparam int BIT_D     = 2;
  localparam int BIT_U     = 3;
  localparam int BIT_B     = 4;
  localparam int BIT_C     = 5;
  localparam int BIT_A     = 6;
  localparam int BIT_START = 7;
  localparam int BIT_Z     = 8;
  localparam int BIT_Y     = 9;
  localparam int BIT_X     = 10;
  localparam int BIT_MODE  = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Even phases drive SELECT high, odd phases drive it low.
  localparam logic [2:0] PH_BASE = 3'd0;  // U D L R B C
  localparam logic [2:0] PH_AST  = 3'd1;  // MD detect, A, Start
  localparam logic [2:0] PH_DET6 = 3'd5;  // 6-button detect
  localparam logic [2:0] PH_XYZ  = 3'd6;  // Z Y X Mode
  localparam logic [2:0] PH_LAST = 3'd7;

endpackage

// File: rtl/db9md_sync.sv
// rtl/db9md_sync.sv - two-flop synchronizer for the raw DB9 pins
//
// Purpose: brings asynchronous pad pins into the clk_sys domain. Resets to
//          all-ones, which is the idle (pulled-up, nothing pressed) pin level.
// Ports:   clk_sys - system clock
//          reset   - synchronous, active-high
//          d_i     - asynchronous input pins
//          q_o     - synchronized pins
module db9md_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/db9md_pad_scan.sv
// rtl/db9md_pad_scan.sv - two-port DB9 Sega 3/6-button pad scanner
//
// Purpose: every IDLE_CYCLES, scans port 1 then port 2 through the external
//          splitter, running eight SELECT half-phases of STEP_CYCLES each per
//          port, and commits both decoded active-high words together.
//          Optional macro DB9MD_DEBOUNCE_EN: a port's result is committed only
//          when it matches that port's result from the previous scan.
// Ports:   clk_sys    - system clock
//          reset      - synchronous, active-high
//          enable     - scanning enabled; low holds everything in reset state
//          joy_in     - raw DB9 pins, active low: Up Down Left Right TL TR
//          joy_split  - splitter port select (0 = port 1, 1 = port 2)
//          joy_mdsel  - SELECT line to the pads
//          joystick1  - port 1 word, active high
//          joystick2  - port 2 word, active high
//          md_present - Mega Drive pad detected, per port
//          six_btn    - 6-button pad detected, per port
//          scan_done  - one-cycle pulse when both words are committed
module db9md_pad_scan
  import db9md_pkg::*;
#(
  parameter int STEP_CYCLES = 256,
  parameter int IDLE_CYCLES = 40000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic [5:0]  joy_in,
  output logic        joy_split,
  output logic        joy_mdsel,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  md_present,
  output logic [1:0]  six_btn,
  output logic        scan_done
);

  localparam int CNT_MAX = (IDLE_CYCLES > STEP_CYCLES) ? IDLE_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [5:0] pins_sync;
  logic [5:0] s;

  db9md_sync #(.WIDTH(6)) u_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d_i     (joy_in),
    .q_o     (pins_sync)
  );

  assign s = ~pins_sync;

  scan_state_e      state_q, state_d;
  logic             port_q, port_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             split_q, split_d;
  logic             mdsel_q, mdsel_d;
  logic [11:0]      word_q, word_d;
  logic             md_q, md_d;
  logic             six_q, six_d;
  logic [11:0]      stage_word_q, stage_word_d;
  logic             stage_md_q, stage_md_d;
  logic             stage_six_q, stage_six_d;
  logic [15:0]      joy1_q, joy1_d;
  logic [15:0]      joy2_q, joy2_d;
  logic [1:0]       md_present_q, md_present_d;
  logic [1:0]       six_btn_q, six_btn_d;
  logic             scan_done_q, scan_done_d;
`ifdef DB9MD_DEBOUNCE_EN
  logic [13:0]      prev0_q, prev0_d;
  logic [13:0]      prev1_q, prev1_d;
  logic [1:0]       prev_valid_q, prev_valid_d;
`endif

  // Per-port results packed as {six, md, word} for commit and comparison.
  logic [11:0] port_word;
  logic [13:0] rec0, rec1;
  logic        commit0, commit1;

  always_ff @(posedge clk_sys) begin
    if (reset || !enable) begin
      state_q      <= ST_IDLE;
      port_q       <= 1'b0;
      phase_q      <= PH_BASE;
      cnt_q        <= '0;
      split_q      <= 1'b0;
      mdsel_q      <= 1'b1;
      word_q       <= '0;
      md_q         <= 1'b0;
      six_q        <= 1'b0;
      stage_word_q <= '0;
      stage_md_q   <= 1'b0;
      stage_six_q  <= 1'b0;
      joy1_q       <= '0;
      joy2_q       <= '0;
      md_present_q <= '0;
      six_btn_q    <= '0;
      scan_done_q  <= 1'b0;
`ifdef DB9MD_DEBOUNCE_EN
      prev0_q      <= '0;
      prev1_q      <= '0;
      prev_valid_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      split_q      <= split_d;
      mdsel_q      <= mdsel_d;
      word_q       <= word_d;
      md_q         <= md_d;
      six_q        <= six_d;
      stage_word_q <= stage_word_d;
      stage_md_q   <= stage_md_d;
      stage_six_q  <= stage_six_d;
      joy1_q       <= joy1_d;
      joy2_q       <= joy2_d;
      md_present_q <= md_present_d;
      six_btn_q    <= six_btn_d;
      scan_done_q  <= scan_done_d;
`ifdef DB9MD_DEBOUNCE_EN
      prev0_q      <= prev0_d;
      prev1_q      <= prev1_d;
      prev_valid_q <= prev_valid_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    split_d      = split_q;
    mdsel_d      = mdsel_q;
    word_d       = word_q;
    md_d         = md_q;
    six_d        = six_q;
    stage_word_d = stage_word_q;
    stage_md_d   = stage_md_q;
    stage_six_d  = stage_six_q;
    joy1_d       = joy1_q;
    joy2_d       = joy2_q;
    md_present_d = md_present_q;
    six_btn_d    = six_btn_q;
    scan_done_d  = 1'b0;
`ifdef DB9MD_DEBOUNCE_EN
    prev0_d      = prev0_q;
    prev1_d      = prev1_q;
    prev_valid_d = prev_valid_q;
`endif
    // Plain Atari/MSX sticks only have directions and two fires.
    port_word = md_q ? word_q : {6'b0, word_q[5:0]};
    rec0      = {stage_six_q, stage_md_q, stage_word_q};
    rec1      = {six_q, md_q, port_word};
    commit0   = 1'b1;
    commit1   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        mdsel_d = 1'b1;
        split_d = 1'b0;
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
          port_d  = 1'b0;
          phase_d = PH_BASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SCAN: begin
        if (cnt_q != STEP_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (phase_q)
            PH_BASE: begin
              word_d         = '0;
              word_d[BIT_U]  = s[0];
              word_d[BIT_D]  = s[1];
              word_d[BIT_L]  = s[2];
              word_d[BIT_R]  = s[3];
              word_d[BIT_B]  = s[4];
              word_d[BIT_C]  = s[5];
            end
            PH_AST: begin
              // An MD pad grounds Left and Right while SELECT is low.
              md_d               = s[2] & s[3];
              word_d[BIT_A]      = s[4];
              word_d[BIT_START]  = s[5];
            end
            PH_DET6: begin
              // On the third low pulse a 6-button pad grounds all four directions.
              six_d = md_q & (s[3:0] == 4'hF);
            end
            PH_XYZ: begin
              word_d[BIT_Z]    = six_q & s[0];
              word_d[BIT_Y]    = six_q & s[1];
              word_d[BIT_X]    = six_q & s[2];
              word_d[BIT_MODE] = six_q & s[3];
            end
            default: ;
          endcase

          if (phase_q == PH_LAST) begin
            phase_d = PH_BASE;
            mdsel_d = 1'b1;
            if (!port_q) begin
              stage_word_d = port_word;
              stage_md_d   = md_q;
              stage_six_d  = six_q;
              port_d       = 1'b1;
              split_d      = 1'b1;
            end else begin
`ifdef DB9MD_DEBOUNCE_EN
              commit0      = prev_valid_q[0] && (rec0 == prev0_q);
              commit1      = prev_valid_q[1] && (rec1 == prev1_q);
              prev0_d      = rec0;
              prev1_d      = rec1;
              prev_valid_d = 2'b11;
`endif
              if (commit0) begin
                joy1_d          = {4'b0, rec0[11:0]};
                md_present_d[0] = rec0[12];
                six_btn_d[0]    = rec0[13];
              end
              if (commit1) begin
                joy2_d          = {4'b0, rec1[11:0]};
                md_present_d[1] = rec1[12];
                six_btn_d[1]    = rec1[13];
              end
              scan_done_d = 1'b1;
              state_d     = ST_IDLE;
              port_d      = 1'b0;
              split_d     = 1'b0;
            end
          end else begin
            phase_d = phase_q + 3'd1;
            // Next phase is odd (SELECT low) exactly when this one is even.
            mdsel_d = phase_q[0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign joy_split  = split_q;
  assign joy_mdsel  = mdsel_q;
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;
  assign md_present = md_present_q;
  assign six_btn    = six_btn_q;
  assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_db9md_pad_scan.sv
// tb/tb_db9md_pad_scan.sv - self-checking bench for db9md_pad_scan with behavioural pads
module tb_db9md_pad_scan;

  localparam int STEP = 4;
  localparam int IDLE = 16;
  localparam int FIRST_DONE = IDLE + 16 * STEP;

  localparam int PAD_NONE  = 0;
  localparam int PAD_ATARI = 1;
  localparam int PAD_MD3   = 2;
  localparam int PAD_MD6   = 3;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [5:0]  joy_in;
  logic        joy_split;
  logic        joy_mdsel;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  md_present;
  logic [1:0]  six_btn;
  logic        scan_done;

  int total = 0;
  int bad = 0;

  db9md_pad_scan #(.STEP_CYCLES(STEP), .IDLE_CYCLES(IDLE)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .enable     (enable),
    .joy_in     (joy_in),
    .joy_split  (joy_split),
    .joy_mdsel  (joy_mdsel),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .md_present (md_present),
    .six_btn    (six_btn),
    .scan_done  (scan_done)
  );

  always #5 clk_sys = ~clk_sys;

  // Pad models: type and pressed buttons (word layout) per port.
  int          pad_type [2];
  logic [11:0] pad_btn  [2];
  int          pad_n = 0;       // SELECT falling edges seen by the selected pad
  int          sel_hi_cnt = 0;  // pad counter timeout
  logic        prev_sel = 1'b1;
  logic        prev_split = 1'b0;

  function automatic logic [5:0] pad_press(int t, logic [11:0] b, logic sel, int n);
    logic [5:0] p;
    p = '0;
    case (t)
      PAD_ATARI: p = {b[5], b[4], b[0], b[1], b[2], b[3]};
      PAD_MD3, PAD_MD6: begin
        if (sel) begin
          if (t == PAD_MD6 && n == 3) p = {b[5], b[4], b[11], b[10], b[9], b[8]};
          else                        p = {b[5], b[4], b[0], b[1], b[2], b[3]};
        end else begin
          if (t == PAD_MD6 && n == 3) p = {b[7], b[6], 4'hF};
          else                        p = {b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  assign joy_in = ~pad_press(pad_type[joy_split], pad_btn[joy_split], joy_mdsel, pad_n);

  always @(negedge clk_sys) begin
    if (joy_split !== prev_split) pad_n = 0;
    else if (prev_sel === 1'b1 && joy_mdsel === 1'b0) pad_n = pad_n + 1;
    if (joy_mdsel === 1'b1) sel_hi_cnt = sel_hi_cnt + 1;
    else sel_hi_cnt = 0;
    if (sel_hi_cnt >= 8) pad_n = 0;
    prev_sel = joy_mdsel;
    prev_split = joy_split;
  end

  // Scoreboard: expected outputs per scan, {six, md, word} per port in the model.
  typedef struct packed {
    logic [15:0] j1;
    logic [15:0] j2;
    logic [1:0]  md;
    logic [1:0]  six;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] m_out [2];
`ifdef DB9MD_DEBOUNCE_EN
  logic [13:0] m_prev  [2];
  logic        m_valid [2];
`endif

  function automatic logic [13:0] pad_expect(int t, logic [11:0] b);
    case (t)
      PAD_ATARI: return {2'b00, 6'b0, b[5:0]};
      PAD_MD3:   return {2'b01, 4'b0, b[7:0]};
      PAD_MD6:   return {2'b11, b};
      default:   return 14'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_out[p] = '0;
`ifdef DB9MD_DEBOUNCE_EN
      m_prev[p]  = '0;
      m_valid[p] = 1'b0;
`endif
    end
  endtask

  task automatic push_expect();
    exp_t e;
    logic [13:0] raw;
    for (int p = 0; p < 2; p++) begin
      raw = pad_expect(pad_type[p], pad_btn[p]);
`ifdef DB9MD_DEBOUNCE_EN
      if (m_valid[p] && raw == m_prev[p]) m_out[p] = raw;
      m_prev[p]  = raw;
      m_valid[p] = 1'b1;
`else
      m_out[p] = raw;
`endif
    end
    e.j1  = {4'b0, m_out[0][11:0]};
    e.j2  = {4'b0, m_out[1][11:0]};
    e.md  = {m_out[1][12], m_out[0][12]};
    e.six = {m_out[1][13], m_out[0][13]};
    sb.push_back(e);
  endtask

  // Runs one scan from IDLE: pushes expectation, waits for scan_done,
  // compares, then checks the pulse is one cycle wide.
  task automatic do_scan(output int cyc, output int hi, output int last_hi);
    exp_t e;
    bit seen;
    push_expect();
    cyc = 0; hi = 0; last_hi = -1; seen = 0;
    while (!seen && cyc < 400) begin
      @(posedge clk_sys);
      cyc++;
      @(negedge clk_sys);
      if (joy_split === 1'b1) begin hi++; last_hi = cyc; end
      if (scan_done === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL scan_timeout: no scan_done after %0d cycles, required within 400", cyc);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      total++;
      if (joystick1 !== e.j1) begin bad++; $display("FAIL sb_joystick1: got %h want %h", joystick1, e.j1); end
      total++;
      if (joystick2 !== e.j2) begin bad++; $display("FAIL sb_joystick2: got %h want %h", joystick2, e.j2); end
      total++;
      if (md_present !== e.md) begin bad++; $display("FAIL sb_md_present: got %b want %b", md_present, e.md); end
      total++;
      if (six_btn !== e.six) begin bad++; $display("FAIL sb_six_btn: got %b want %b", six_btn, e.six); end
      @(posedge clk_sys);
      @(negedge clk_sys);
      total++;
      if (scan_done !== 1'b0) begin bad++; $display("FAIL scan_done_width: got %b want 0", scan_done); end
    end
  endtask

  task automatic test_reset();
    int cyc, hi, lh;
    model_reset();
    pad_type[0] = PAD_MD6; pad_btn[0] = '0;
    pad_type[1] = PAD_MD6; pad_btn[1] = '0;
    reset = 1'b1; enable = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    total++; if (joy_split !== 1'b0) begin bad++; $display("FAIL rst_split: got %b want 0", joy_split); end
    total++; if (joy_mdsel !== 1'b1) begin bad++; $display("FAIL rst_mdsel: got %b want 1", joy_mdsel); end
    total++; if (joystick1 !== 16'h0) begin bad++; $display("FAIL rst_j1: got %h want 0000", joystick1); end
    total++; if (joystick2 !== 16'h0) begin bad++; $display("FAIL rst_j2: got %h want 0000", joystick2); end
    total++; if (md_present !== 2'b00) begin bad++; $display("FAIL rst_md: got %b want 00", md_present); end
    total++; if (six_btn !== 2'b00) begin bad++; $display("FAIL rst_six: got %b want 00", six_btn); end
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", scan_done); end
    reset = 1'b0;
    do_scan(cyc, hi, lh);
    total++;
    if (cyc !== FIRST_DONE) begin bad++; $display("FAIL first_done_latency: got %0d want %0d", cyc, FIRST_DONE); end
  endtask

  task automatic test_port1_md3();
    int cyc, hi, lh;
    pad_type[0] = PAD_MD3;  pad_btn[0] = 12'h0C8;
    pad_type[1] = PAD_NONE; pad_btn[1] = '0;
    do_scan(cyc, hi, lh);
    do_scan(cyc, hi, lh);
    total++; if (joystick1 !== 16'h00C8) begin bad++; $display("FAIL md3_j1: got %h want 00c8", joystick1); end
    total++; if (md_present !== 2'b01) begin bad++; $display("FAIL md3_present: got %b want 01", md_present); end
    total++; if (joystick2 !== 16'h0000) begin bad++; $display("FAIL md3_j2: got %h want 0000", joystick2); end
  endtask

  task automatic test_port2_md6();
    int cyc, hi, lh;
    pad_type[0] = PAD_NONE; pad_btn[0] = '0;
    pad_type[1] = PAD_MD6;  pad_btn[1] = 12'hC20;
    do_scan(cyc, hi, lh);
    do_scan(cyc, hi, lh);
    total++; if (joystick2 !== 16'h0C20) begin bad++; $display("FAIL md6_j2: got %h want 0c20", joystick2); end
    total++; if (six_btn[1] !== 1'b1) begin bad++; $display("FAIL md6_six: got %b want 1", six_btn[1]); end
    total++; if (hi !== 32) begin bad++; $display("FAIL split_window_len: got %0d want 32", hi); end
    total++; if (lh !== cyc - 1) begin bad++; $display("FAIL split_window_end: got %0d want %0d", lh, cyc - 1); end
  endtask

  task automatic test_atari();
    int cyc, hi, lh;
    pad_type[0] = PAD_ATARI; pad_btn[0] = 12'h011;
    pad_type[1] = PAD_NONE;  pad_btn[1] = '0;
    do_scan(cyc, hi, lh);
    do_scan(cyc, hi, lh);
    total++; if (joystick1 !== 16'h0011) begin bad++; $display("FAIL atari_j1: got %h want 0011", joystick1); end
    total++; if (md_present[0] !== 1'b0) begin bad++; $display("FAIL atari_md: got %b want 0", md_present[0]); end
    total++; if (joystick1[11:6] !== 6'h0) begin bad++; $display("FAIL atari_hi_bits: got %h want 00", joystick1[11:6]); end
  endtask

  task automatic test_back_to_back();
    int cyc, hi, lh;
    for (int i = 0; i < 4; i++) begin
      pad_type[0] = PAD_MD6; pad_btn[0] = 12'($urandom_range(0, 4095));
      pad_type[1] = PAD_MD6; pad_btn[1] = 12'($urandom_range(0, 4095));
      do_scan(cyc, hi, lh);
    end
  endtask

`ifdef DB9MD_DEBOUNCE_EN
  task automatic test_debounce();
    int cyc, hi, lh;
    pad_type[0] = PAD_MD6;  pad_btn[0] = '0;
    pad_type[1] = PAD_NONE; pad_btn[1] = '0;
    do_scan(cyc, hi, lh);
    do_scan(cyc, hi, lh);
    for (int i = 0; i < 4; i++) begin
      pad_btn[0] = (i % 2 == 0) ? 12'h010 : 12'h000;
      do_scan(cyc, hi, lh);
      total++;
      if (joystick1[4] !== 1'b0) begin bad++; $display("FAIL deb_toggle_%0d: got %b want 0", i, joystick1[4]); end
    end
    pad_btn[0] = 12'h010;
    do_scan(cyc, hi, lh);
    total++; if (joystick1[4] !== 1'b0) begin bad++; $display("FAIL deb_hold_first: got %b want 0", joystick1[4]); end
    do_scan(cyc, hi, lh);
    total++; if (joystick1[4] !== 1'b1) begin bad++; $display("FAIL deb_hold_second: got %b want 1", joystick1[4]); end
  endtask
`endif

  task automatic test_disable();
    int cyc, hi, lh;
    bit saw;
    pad_type[0] = PAD_MD6; pad_btn[0] = 12'h0FF;
    pad_type[1] = PAD_MD3; pad_btn[1] = 12'h0C0;
    do_scan(cyc, hi, lh);
    do_scan(cyc, hi, lh);
    repeat (61) @(posedge clk_sys);
    @(negedge clk_sys);
    total++;
    if (joy_split !== 1'b1 || joy_mdsel !== 1'b0) begin
      bad++; $display("FAIL abort_point: got split=%b sel=%b want split=1 sel=0", joy_split, joy_mdsel);
    end
    enable = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    total++; if (joystick1 !== 16'h0) begin bad++; $display("FAIL dis_j1: got %h want 0000", joystick1); end
    total++; if (joystick2 !== 16'h0) begin bad++; $display("FAIL dis_j2: got %h want 0000", joystick2); end
    total++; if (md_present !== 2'b00) begin bad++; $display("FAIL dis_md: got %b want 00", md_present); end
    total++; if (six_btn !== 2'b00) begin bad++; $display("FAIL dis_six: got %b want 00", six_btn); end
    total++; if (joy_mdsel !== 1'b1) begin bad++; $display("FAIL dis_mdsel: got %b want 1", joy_mdsel); end
    total++; if (joy_split !== 1'b0) begin bad++; $display("FAIL dis_split: got %b want 0", joy_split); end
    saw = 0;
    repeat (100) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (scan_done !== 1'b0) saw = 1;
    end
    total++; if (saw) begin bad++; $display("FAIL dis_no_done: got scan_done=1 want none"); end
    model_reset();
    enable = 1'b1;
    do_scan(cyc, hi, lh);
    total++;
    if (cyc !== FIRST_DONE) begin bad++; $display("FAIL reenable_latency: got %0d want %0d", cyc, FIRST_DONE); end
  endtask

  initial begin
    pad_type[0] = PAD_NONE; pad_type[1] = PAD_NONE;
    pad_btn[0] = '0; pad_btn[1] = '0;
    test_reset();
    test_port1_md3();
    test_port2_md6();
    test_atari();
    test_back_to_back();
`ifdef DB9MD_DEBOUNCE_EN
    test_debounce();
`endif
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
